uart_cmd_rx: RTL and testbench

Parametrised UART command receiver feeding the flight-command path of `drone_top`. It oversamples the asynchronous `RxD` line, validates start, optional parity and stop bits, and pushes good bytes into a show-ahead FIFO for the command decoder. It supersedes the fixed 8N1 single-byte receiver and adds:

- configurable baud, data width and parity;
- glitch rejection;
- error flags;
- buffering of back-to-back commands.

---
 rtl/drone_uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_cmd_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drone_uart_pkg.sv
// Shared definitions for the drone UART paths: parity modes, receive FSM encoding
// and elaboration-time helpers.
package drone_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Rounded divide so the tick period lands on the nearest whole clock count.
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        int step;
        step = baud * oversample;
        return (clk_hz + step / 2) / step;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The occupancy counter tells full from empty, so the
// pointers simply wrap at DEPTH (a power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot being written, so push+pop on a full FIFO is legal.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: 2-FF synchroniser, oversample tick, frame FSM, show-ahead FIFO.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | half-bit wait, confirm the start bit is still low
//   DATA      | sample payload bits LSB first
//   PARITY    | sample parity bit, remember a mismatch
//   STOP      | sample stop bit, then flag, push or drop
//   WAIT_HIGH | framing error or break; hold until the line returns high
module uart_cmd_rx
    import drone_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RxD,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_M1   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BITS_M1 = BIT_W'(DATA_BITS - 1);

    logic                 r_sync;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [DIV_W-1:0]     r_div_cnt;
    logic                 r_tick;
    rx_state_t            r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_push;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic                 w_fall;
    logic                 w_sample;
    logic                 w_par_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= RxD;
            r_rx_s    <= r_sync;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall = r_rx_prev && !r_rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= DIV_M1;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == '0) begin
            r_div_cnt <= DIV_M1;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
            r_tick    <= 1'b0;
        end
    end

    assign w_sample  = r_tick && (r_os_cnt == '0);
    assign w_par_exp = (PARITY == PAR_EVEN) ? (^r_shift) : ~(^r_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if (r_tick && r_os_cnt != '0) r_os_cnt <= r_os_cnt - 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_perr <= 1'b0;
                    if (w_fall) begin
                        r_state  <= ST_START;
                        r_os_cnt <= HALF_M1;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_os_cnt  <= OS_M1;
                            r_bit_cnt <= BITS_M1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift  <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_os_cnt <= OS_M1;
                        if (r_bit_cnt != '0) begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end else if (PARITY != PAR_NONE) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        if (r_rx_s != w_par_exp) r_perr <= 1'b1;
                        r_os_cnt <= OS_M1;
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (w_sample) begin
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_HIGH;
                        end else if (r_perr) begin
                            r_parity_err <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_push  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (r_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The FIFO decides acceptance on the push cycle, so overrun follows it by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push && full && !rd_en;
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .pop   (rd_en),
        .din   (r_shift),
        .dout  (rd_data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: four instances run side by side (three 8N1, one even parity)
// so the long overrun fills overlap with the shorter scenarios.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    import drone_uart_pkg::*;

    localparam int BIT_NS = 8680;
    localparam int NDUT   = 4;

    logic       clk   = 1'b0;
    logic [3:0] rst   = 4'hF;
    logic [3:0] rxd   = 4'hF;
    logic [3:0] rd_en = 4'h0;

    wire [7:0] rdd [NDUT];
    wire [4:0] cnt [NDUT];
    wire [3:0] emp, ful, fe, pe, ov;

    int fe_cnt [NDUT];
    int pe_cnt [NDUT];
    int ov_cnt [NDUT];
    int wide_cnt = 0;
    bit [3:0] fe_q = '0, pe_q = '0, ov_q = '0;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        uart_cmd_rx #(
            .PARITY ((g == 3) ? 2 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .RxD        (rxd[g]),
            .rd_en      (rd_en[g]),
            .rd_data    (rdd[g]),
            .empty      (emp[g]),
            .full       (ful[g]),
            .count      (cnt[g]),
            .frame_err  (fe[g]),
            .parity_err (pe[g]),
            .overrun    (ov[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (fe[k]) fe_cnt[k] <= fe_cnt[k] + 1;
            if (pe[k]) pe_cnt[k] <= pe_cnt[k] + 1;
            if (ov[k]) ov_cnt[k] <= ov_cnt[k] + 1;
        end
        if (|(fe & fe_q) || |(pe & pe_q) || |(ov & ov_q)) wide_cnt <= wide_cnt + 1;
        fe_q <= fe;
        pe_q <= pe;
        ov_q <= ov;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // par < 0 sends no parity bit; otherwise par[0] is the parity bit value.
    task automatic send_frame(input int ln, input logic [7:0] d, input int par, input logic stop_lvl);
        rxd[ln] = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd[ln] = d[i];
            #(BIT_NS);
        end
        if (par >= 0) begin
            rxd[ln] = par[0];
            #(BIT_NS);
        end
        rxd[ln] = stop_lvl;
        #(BIT_NS);
    endtask

    task automatic pop_chk(input int ln, input logic [7:0] want, input string tag);
        @(negedge clk);
        check(tag, rdd[ln], want);
        rd_en[ln] = 1'b1;
        @(negedge clk);
        rd_en[ln] = 1'b0;
    endtask

    task automatic run_dut0();
        int fe0, pe0, ov0;
        logic [3:0] lead;
        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];

        rxd[0] = 1'b0;
        #1000;
        rxd[0] = 1'b1;
        #(2 * BIT_NS);
        check("glitch_count", cnt[0], 0);
        check("glitch_flags", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);

        send_frame(0, 8'h55, -1, 1'b0);
        #(2 * BIT_NS);
        check("frame_err_pulses", fe_cnt[0] - fe0, 1);
        check("frame_no_push", cnt[0], 0);
        check("frame_wait_high", gen_dut[0].u_dut.r_state, ST_WAIT_HIGH);
        rxd[0] = 1'b1;
        #(BIT_NS);
        check("frame_back_idle", gen_dut[0].u_dut.r_state, ST_IDLE);
        check("frame_still_empty", emp[0], 1);

        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
        send_frame(0, 8'h01, -1, 1'b1);
        wait_cyc(3);
        check("single_empty", emp[0], 0);
        check("single_rd_data", rdd[0], 8'h01);
        check("single_count", cnt[0], 1);
        check("single_flags", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);
        pop_chk(0, 8'h01, "single_pop");
        wait_cyc(1);
        check("single_drained", emp[0], 1);

        send_frame(0, 8'h01, -1, 1'b1);
        send_frame(0, 8'h03, -1, 1'b1);
        wait_cyc(3);
        check("b2b_count", cnt[0], 2);
        pop_chk(0, 8'h01, "b2b_pop0");
        pop_chk(0, 8'h03, "b2b_pop1");
        wait_cyc(1);
        check("b2b_empty", emp[0], 1);
        check("b2b_count_end", cnt[0], 0);
        check("b2b_flags", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);

        send_frame(0, 8'h01, -1, 1'b1);
        wait_cyc(3);
        check("pre_rst_count", cnt[0], 1);
        lead = 4'b0011;
        rxd[0] = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd[0] = lead[i];
            #(BIT_NS);
        end
        rxd[0] = 1'b0;
        #(BIT_NS / 2);
        rxd[0] = 1'b1;
        rst[0] = 1'b1;
        #50;
        check("rst_mid_empty", emp[0], 1);
        check("rst_mid_full", ful[0], 0);
        check("rst_mid_count", cnt[0], 0);
        check("rst_mid_rd_data", rdd[0], 0);
        check("rst_mid_pulses", {fe[0], pe[0], ov[0]}, 0);
        check("rst_mid_state", gen_dut[0].u_dut.r_state, ST_IDLE);
        #50;
        rst[0] = 1'b0;
        #(2 * BIT_NS);
        check("rst_after_count", cnt[0], 0);
        check("rst_after_flags", (fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0), 0);
        send_frame(0, 8'h03, -1, 1'b1);
        wait_cyc(3);
        check("rst_next_count", cnt[0], 1);
        check("rst_next_rd_data", rdd[0], 8'h03);
    endtask

    task automatic run_dut1();
        int ov0;
        ov0 = ov_cnt[1];
        for (int i = 0; i < 16; i++) begin
            send_frame(1, 8'(i), -1, 1'b1);
            if (i == 14) begin
                wait_cyc(1);
                check("ovr_15_not_full", ful[1], 0);
                check("ovr_15_count", cnt[1], 15);
            end
        end
        wait_cyc(2);
        check("ovr_16_full", ful[1], 1);
        check("ovr_16_count", cnt[1], 16);
        send_frame(1, 8'h10, -1, 1'b1);
        wait_cyc(3);
        check("ovr_pulses", ov_cnt[1] - ov0, 1);
        check("ovr_count_kept", cnt[1], 16);
        check("ovr_full_kept", ful[1], 1);
        for (int i = 0; i < 16; i++) pop_chk(1, 8'(i), "ovr_pop");
        wait_cyc(1);
        check("ovr_drained", emp[1], 1);
    endtask

    task automatic run_dut2();
        int ov0;
        int n;
        for (int i = 0; i < 16; i++) send_frame(2, 8'(i), -1, 1'b1);
        wait_cyc(2);
        check("acc_full", ful[2], 1);
        ov0 = ov_cnt[2];
        n = 0;
        fork
            send_frame(2, 8'h10, -1, 1'b1);
            begin
                @(negedge clk);
                while (gen_dut[2].u_dut.r_push !== 1'b1 && n < 20000) begin
                    @(negedge clk);
                    n++;
                end
                check("acc_push_seen", gen_dut[2].u_dut.r_push, 1);
                check("acc_head", rdd[2], 8'h00);
                rd_en[2] = 1'b1;
                @(negedge clk);
                rd_en[2] = 1'b0;
            end
        join
        wait_cyc(3);
        check("acc_no_overrun", ov_cnt[2] - ov0, 0);
        check("acc_count", cnt[2], 16);
        check("acc_full_kept", ful[2], 1);
        for (int i = 1; i <= 16; i++) pop_chk(2, 8'(i), "acc_pop");
        wait_cyc(1);
        check("acc_drained", emp[2], 1);
    endtask

    task automatic run_dut3();
        int fe0, pe0;
        fe0 = fe_cnt[3]; pe0 = pe_cnt[3];
        send_frame(3, 8'h03, 1, 1'b1);
        wait_cyc(3);
        check("par_bad_pulses", pe_cnt[3] - pe0, 1);
        check("par_bad_count", cnt[3], 0);
        check("par_bad_no_frame", fe_cnt[3] - fe0, 0);
        send_frame(3, 8'h03, 0, 1'b1);
        wait_cyc(3);
        check("par_good_count", cnt[3], 1);
        check("par_good_rd_data", rdd[3], 8'h03);
        check("par_good_no_err", pe_cnt[3] - pe0, 1);
    endtask

    initial begin
        #50;
        check("rst_empty", emp, 4'hF);
        check("rst_full", ful, 4'h0);
        check("rst_count", cnt[0], 0);
        check("rst_rd_data", rdd[0], 0);
        check("rst_pulses", {fe, pe, ov}, 0);
        #50;
        rst = 4'h0;
        wait_cyc(5);
        check("post_rst_empty", emp, 4'hF);
        fork
            run_dut0();
            run_dut1();
            run_dut2();
            run_dut3();
        join
        check("pulse_width", wide_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
